// File: rtl/frame_snapshot_pkg.sv
// Shared types and constants for the frame-coherent game-state double buffer.
package frame_snapshot_pkg;

  localparam int N_OBS         = 10;
  localparam int X_W           = 10;
  localparam int Y_W           = 9;
  localparam int SETTLE_CYCLES = 4;
  localparam int CNT_W         = $clog2(SETTLE_CYCLES) + 1;

  localparam int RST_OBS_X    = 700;
  localparam int RST_OBS_Y    = 500;
  localparam int RST_PLAYER_Y = 240;

  typedef logic [N_OBS-1:0][X_W-1:0] obs_x_arr_t;
  typedef logic [N_OBS-1:0][Y_W-1:0] obs_y_arr_t;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} snap_state_e;

  typedef struct packed {
    obs_x_arr_t     x_left;
    obs_x_arr_t     x_right;
    obs_y_arr_t     y_up;
    obs_y_arr_t     y_down;
    logic [Y_W-1:0] player_y;
    logic [1:0]     gamemode;
  } snap_t;

  localparam snap_t SNAP_RST = '{
    x_left:   {N_OBS{X_W'(RST_OBS_X)}},
    x_right:  {N_OBS{X_W'(RST_OBS_X)}},
    y_up:     {N_OBS{Y_W'(RST_OBS_Y)}},
    y_down:   {N_OBS{Y_W'(RST_OBS_Y)}},
    player_y: Y_W'(RST_PLAYER_Y),
    gamemode: 2'd0
  };

endpackage

// File: rtl/frame_snapshot_sync_rise_det.sv
// Two-flop synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
// rise_o is combinational from the flops: 2-3 clk cycles after the input edge.
module sync_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic sync1_q, sync2_q, sync2_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync2_dly_q <= 1'b0;
    end else begin
      sync1_q     <= d_i;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~sync2_dly_q;

endmodule

// File: rtl/frame_snapshot.sv
// Captures settled game state after each tick into staging; commits staging to display on vsync fall.
// No backpressure: newer captures overwrite staging; FRAME_SNAPSHOT_DROP_CNT_EN enables drop_count.
module frame_snapshot
  import frame_snapshot_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           tick_60hz,
  input  logic           vs,
  input  obs_x_arr_t     obstacle_x_left_in,
  input  obs_x_arr_t     obstacle_x_right_in,
  input  obs_y_arr_t     obstacle_y_up_in,
  input  obs_y_arr_t     obstacle_y_down_in,
  input  logic [Y_W-1:0] player_y_in,
  input  logic [1:0]     gamemode_in,
  output obs_x_arr_t     obstacle_x_left_out,
  output obs_x_arr_t     obstacle_x_right_out,
  output obs_y_arr_t     obstacle_y_up_out,
  output obs_y_arr_t     obstacle_y_down_out,
  output logic [Y_W-1:0] player_y_out,
  output logic [1:0]     gamemode_out,
  output logic           frame_updated,
  output logic [7:0]     drop_count
);

  snap_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vs_dly_q, pending_q, frame_updated_q;
  snap_t            stage_q, disp_q, snap_in;
  logic             tick_rise, vs_fall, capture, commit;

  sync_rise_det u_tick_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (tick_60hz),
    .rise_o (tick_rise)
  );

  assign vs_fall = ~vs & vs_dly_q;
  assign snap_in = {obstacle_x_left_in, obstacle_x_right_in, obstacle_y_up_in,
                    obstacle_y_down_in, player_y_in, gamemode_in};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick_rise) begin
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // A fresh tick means the game side is still changing: restart the wait.
        if (tick_rise) begin
          cnt_d = CNT_W'(SETTLE_CYCLES - 1);
        end else if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Staging is being rewritten during CAPTURE, so a coinciding vsync defers to the next one.
  assign commit = vs_fall & pending_q & ~capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      vs_dly_q        <= 1'b1;
      pending_q       <= 1'b0;
      frame_updated_q <= 1'b0;
      stage_q         <= SNAP_RST;
      disp_q          <= SNAP_RST;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      vs_dly_q        <= vs;
      frame_updated_q <= commit;
      if (capture) begin
        stage_q   <= snap_in;
        pending_q <= 1'b1;
      end else if (commit) begin
        disp_q    <= stage_q;
        pending_q <= 1'b0;
      end
    end
  end

`ifdef FRAME_SNAPSHOT_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (capture && pending_q && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= 8'd0;
    else     drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 8'd0;
`endif

  assign obstacle_x_left_out  = disp_q.x_left;
  assign obstacle_x_right_out = disp_q.x_right;
  assign obstacle_y_up_out    = disp_q.y_up;
  assign obstacle_y_down_out  = disp_q.y_down;
  assign player_y_out         = disp_q.player_y;
  assign gamemode_out         = disp_q.gamemode;
  assign frame_updated        = frame_updated_q;

endmodule

// File: tb/tb_frame_snapshot.sv
// Bench for frame_snapshot: directed table, multi-cycle corner sequences and a randomized run
// checked every cycle against an event-level model of tick -> settle -> capture -> vsync commit.
module tb_frame_snapshot;
  import frame_snapshot_pkg::*;

`ifdef FRAME_SNAPSHOT_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tick_60hz = 1'b0;
  logic           vs = 1'b1;
  obs_x_arr_t     x_left_in, x_right_in, x_left_out, x_right_out;
  obs_y_arr_t     y_up_in, y_down_in, y_up_out, y_down_out;
  logic [8:0]     player_y_in, player_y_out;
  logic [1:0]     gamemode_in, gamemode_out;
  logic           frame_updated;
  logic [7:0]     drop_count;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  frame_snapshot dut (
    .clk                  (clk),
    .rst                  (rst),
    .tick_60hz            (tick_60hz),
    .vs                   (vs),
    .obstacle_x_left_in   (x_left_in),
    .obstacle_x_right_in  (x_right_in),
    .obstacle_y_up_in     (y_up_in),
    .obstacle_y_down_in   (y_down_in),
    .player_y_in          (player_y_in),
    .gamemode_in          (gamemode_in),
    .obstacle_x_left_out  (x_left_out),
    .obstacle_x_right_out (x_right_out),
    .obstacle_y_up_out    (y_up_out),
    .obstacle_y_down_out  (y_down_out),
    .player_y_out         (player_y_out),
    .gamemode_out         (gamemode_out),
    .frame_updated        (frame_updated),
    .drop_count           (drop_count)
  );

  always #5 clk = ~clk;

  function automatic obs_x_arr_t mk_x(input logic [9:0] v);
    obs_x_arr_t r;
    for (int i = 0; i < N_OBS; i++) r[i] = v + 10'(i);
    return r;
  endfunction

  function automatic obs_y_arr_t mk_y(input logic [8:0] v);
    obs_y_arr_t r;
    for (int i = 0; i < N_OBS; i++) r[i] = v + 9'(i);
    return r;
  endfunction

  function automatic snap_t rst_bundle();
    snap_t b;
    for (int i = 0; i < N_OBS; i++) begin
      b.x_left[i]  = 10'd700;
      b.x_right[i] = 10'd700;
      b.y_up[i]    = 9'd500;
      b.y_down[i]  = 9'd500;
    end
    b.player_y = 9'd240;
    b.gamemode = 2'd0;
    return b;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_inputs(input logic [9:0] xv, input logic [8:0] py, input logic [1:0] gm);
    logic [8:0] yv;
    yv          = xv[8:0];
    x_left_in   = mk_x(xv);
    x_right_in  = mk_x(xv ^ 10'h155);
    y_up_in     = mk_y(yv);
    y_down_in   = mk_y(~yv);
    player_y_in = py;
    gamemode_in = gm;
  endtask

  // Called at a negedge; returns at the next negedge, after the posedge that sampled t/v.
  task automatic drive(input bit t, input bit v);
    tick_60hz = t;
    vs        = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick_60hz = 1'b0; vs = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: a rise of the tick level is seen two sampled edges later; capture lands
  // SETTLE_CYCLES+1 edges after the most recent rise; commits happen on vs falls with data pending.
  snap_t   m_stage, m_disp, m_in;
  bit      m_pend, m_fu, m_rise, m_vfall, m_cap;
  int      m_drop;
  longint  cyc_n = 0, due = -1;
  bit      th0, th1, th2, vs_prev;

  always @(posedge clk) begin
    cyc_n++;
    m_in = {x_left_in, x_right_in, y_up_in, y_down_in, player_y_in, gamemode_in};
    if (rst) begin
      m_stage = rst_bundle(); m_disp = rst_bundle();
      m_pend = 0; m_fu = 0; m_drop = 0; due = -1;
      th0 = 0; th1 = 0; th2 = 0; vs_prev = 1;
    end else begin
      m_rise  = th1 & ~th2;
      m_vfall = !vs && vs_prev;
      m_cap   = (cyc_n == due);
      m_fu    = 0;
      if (m_cap) begin
        if (m_pend && m_drop < 255) m_drop++;
        m_pend  = 1;
        m_stage = m_in;
      end else if (m_vfall && m_pend) begin
        m_disp = m_stage;
        m_pend = 0;
        m_fu   = 1;
      end
      if (m_rise && !m_cap) due = cyc_n + SETTLE_CYCLES + 1;
      th2 = th1; th1 = th0; th0 = tick_60hz; vs_prev = vs;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model player_y", 128'(player_y_out), 128'(m_disp.player_y));
      check("model gamemode", 128'(gamemode_out), 128'(m_disp.gamemode));
      check("model x_left", 128'(x_left_out), 128'(m_disp.x_left));
      check("model x_right", 128'(x_right_out), 128'(m_disp.x_right));
      check("model y_up", 128'(y_up_out), 128'(m_disp.y_up));
      check("model y_down", 128'(y_down_out), 128'(m_disp.y_down));
      check("model frame_updated", 128'(frame_updated), 128'(m_fu));
      check("model drop_count", 128'(drop_count), DROP_EN ? 128'(m_drop) : 128'd0);
    end
  end

  typedef struct {
    bit         do_tick;
    logic [9:0] xv;
    logic [8:0] py;
    logic [1:0] gm;
    logic [9:0] exp_xv;
    logic [8:0] exp_py;
    logic [1:0] exp_gm;
    bit         exp_fu;
  } vec_t;

  vec_t  tbl[5];
  snap_t rb;
  int    thold, vcnt;

  initial begin
    tbl[0] = '{1'b1, 10'd5,    9'd17,  2'd1, 10'd5,    9'd17,  2'd1, 1'b1};
    tbl[1] = '{1'b0, 10'd600,  9'd300, 2'd2, 10'd5,    9'd17,  2'd1, 1'b0};
    tbl[2] = '{1'b1, 10'd1000, 9'd511, 2'd3, 10'd1000, 9'd511, 2'd3, 1'b1};
    tbl[3] = '{1'b1, 10'd0,    9'd0,   2'd0, 10'd0,    9'd0,   2'd0, 1'b1};
    tbl[4] = '{1'b0, 10'd1,    9'd1,   2'd1, 10'd0,    9'd0,   2'd0, 1'b0};

    set_inputs(10'd3, 9'd3, 2'd3);
    @(negedge clk);

    // T1 reset values
    do_reset();
    chk_en = 1'b1;
    rb = rst_bundle();
    check("T1 player_y", 128'(player_y_out), 128'(rb.player_y));
    check("T1 gamemode", 128'(gamemode_out), 128'(rb.gamemode));
    check("T1 x_left", 128'(x_left_out), 128'(rb.x_left));
    check("T1 y_up", 128'(y_up_out), 128'(rb.y_up));
    check("T1 frame_updated", 128'(frame_updated), 128'd0);
    check("T1 drop_count", 128'(drop_count), 128'd0);

    // T2 basic capture then commit exactly on the vs fall edge
    do_reset();
    set_inputs(10'd50, 9'd100, 2'd2);
    drive(1, 1);
    repeat (9) drive(0, 1);
    check("T2 before vs", 128'(player_y_out), 128'd240);
    drive(0, 0);
    check("T2 player_y", 128'(player_y_out), 128'd100);
    check("T2 x_left", 128'(x_left_out), 128'(mk_x(10'd50)));
    check("T2 pulse", 128'(frame_updated), 128'd1);
    drive(0, 1);
    check("T2 pulse end", 128'(frame_updated), 128'd0);

    // T3 settle restart: rises at edges 2 and 4, capture at edge 9
    do_reset();
    set_inputs(10'd7, 9'd66, 2'd1);
    for (int e = 0; e < 12; e++) begin
      player_y_in = (e < 3) ? 9'd66 : ((e < 10) ? 9'd77 : 9'd88);
      drive(e == 0 || e == 2, !(e == 8 || e == 10));
      if (e == 8) check("T3 early vs no commit", 128'(frame_updated), 128'd0);
      if (e == 10) begin
        check("T3 player_y", 128'(player_y_out), 128'd77);
        check("T3 pulse", 128'(frame_updated), 128'd1);
      end
    end

    // T4 vs fall during CAPTURE with older data pending: deferred, newest data committed later
    do_reset();
    set_inputs(10'd9, 9'd111, 2'd2);
    for (int e = 0; e < 21; e++) begin
      player_y_in = (e < 8) ? 9'd111 : 9'd123;
      drive(e == 0 || e == 10, !(e == 17 || e == 19));
      if (e == 17) begin
        check("T4 collide no pulse", 128'(frame_updated), 128'd0);
        check("T4 collide display", 128'(player_y_out), 128'd240);
      end
      if (e == 19) begin
        check("T4 late commit", 128'(player_y_out), 128'd123);
        check("T4 late pulse", 128'(frame_updated), 128'd1);
      end
    end
    check("T4 drop_count", 128'(drop_count), DROP_EN ? 128'd1 : 128'd0);

    // T5 three ticks, no vsync in between
    do_reset();
    set_inputs(10'd20, 9'd0, 2'd3);
    for (int k = 0; k < 3; k++) begin
      player_y_in = 9'(11 * (k + 1));
      drive(1, 1);
      repeat (9) drive(0, 1);
    end
    check("T5 drop_count", 128'(drop_count), DROP_EN ? 128'd2 : 128'd0);
    drive(0, 0);
    check("T5 latest wins", 128'(player_y_out), 128'd33);
    drive(0, 1);

    // T6 table: captured frames and idle frames
    do_reset();
    for (int r = 0; r < 5; r++) begin
      set_inputs(tbl[r].xv, tbl[r].py, tbl[r].gm);
      drive(tbl[r].do_tick, 1);
      repeat (9) drive(0, 1);
      drive(0, 0);
      check($sformatf("T6[%0d] player_y", r), 128'(player_y_out), 128'(tbl[r].exp_py));
      check($sformatf("T6[%0d] gamemode", r), 128'(gamemode_out), 128'(tbl[r].exp_gm));
      check($sformatf("T6[%0d] x_left", r), 128'(x_left_out), 128'(mk_x(tbl[r].exp_xv)));
      check($sformatf("T6[%0d] y_down", r), 128'(y_down_out), 128'(mk_y(~tbl[r].exp_xv[8:0])));
      check($sformatf("T6[%0d] pulse", r), 128'(frame_updated), 128'(tbl[r].exp_fu));
      drive(0, 1);
    end

    // T7 drop counter saturation
    do_reset();
    repeat (258) begin
      drive(1, 1);
      repeat (7) drive(0, 1);
    end
    repeat (3) drive(0, 1);
    check("T7 drop saturate", 128'(drop_count), DROP_EN ? 128'd255 : 128'd0);

    // Randomized run with bursty ticks, short vsync pulses and occasional mid-run reset
    do_reset();
    thold = 1; vcnt = 5;
    for (int c = 0; c < 6000; c++) begin
      thold--;
      if (thold <= 0) begin
        tick_60hz = ~tick_60hz;
        thold = $urandom_range(1, 12);
      end
      vcnt--;
      if (vcnt <= 0) begin
        vs   = ~vs;
        vcnt = vs ? $urandom_range(3, 25) : $urandom_range(1, 3);
      end
      rst = ($urandom_range(0, 799) == 0);
      set_inputs(10'($urandom), 9'($urandom), 2'($urandom));
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
